// File: rtl/chunk_add_seq_if.sv
// Client-side bundle for chunk_add_seq: request, operands and the registered result.
// Defining CHUNK_ADD_SEQ_OVF_EN adds the signed-overflow flag ovf.
interface chunk_add_seq_if #(
    parameter int N = 8,
    parameter int K = 4
);
    localparam int W = N * K;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CHUNK_ADD_SEQ_OVF_EN
    logic         ovf;
`endif

    modport master (
        output start, a, b, cin,
`ifdef CHUNK_ADD_SEQ_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef CHUNK_ADD_SEQ_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/chunk_add_seq.sv
// Multi-precision adder: one N-bit adder reused over K cycles, LS chunk first.
// Optional feature macro: CHUNK_ADD_SEQ_OVF_EN (adds the signed overflow flag ovf).
module chunk_add_seq #(
    parameter int N = 8,
    parameter int K = 4
) (
    input logic            clk,
    input logic            rst,
    chunk_add_seq_if.slave bus_io
);
    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  aOp_q, aOp_d;
    logic [W-1:0]  bOp_q, bOp_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
`ifdef CHUNK_ADD_SEQ_OVF_EN
    logic          ovf_q, ovf_d;
    logic          msbCarryIn;
`endif

    logic          accept;
    logic          lastChunk;
    logic [N-1:0]  chunkA, chunkB, chunkSum;
    logic          chunkCarry;

    assign accept    = bus_io.start && ((state_q == IDLE) || (state_q == DONE));
    assign lastChunk = (idx_q == LAST_IDX);

    // The single shared N-bit ripple adder, fed from the private operand copies.
    assign chunkA = aOp_q[idx_q*N +: N];
    assign chunkB = bOp_q[idx_q*N +: N];
    assign {chunkCarry, chunkSum} = {1'b0, chunkA} + {1'b0, chunkB} + {{N{1'b0}}, carry_q};
`ifdef CHUNK_ADD_SEQ_OVF_EN
    assign msbCarryIn = chunkA[N-1] ^ chunkB[N-1] ^ chunkSum[N-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            aOp_q   <= '0;
            bOp_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CHUNK_ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            aOp_q   <= aOp_d;
            bOp_q   <= bOp_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CHUNK_ADD_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus_io.start) state_d = RUN;
            RUN:     if (lastChunk) state_d = DONE;
            DONE:    state_d = bus_io.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_io.busy = (state_q == RUN);
        bus_io.done = (state_q == DONE);
    end

    // Result and flags only change at the final chunk; sum slices land one per cycle.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        aOp_d   = aOp_q;
        bOp_d   = bOp_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CHUNK_ADD_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            aOp_d   = bus_io.a;
            bOp_d   = bus_io.b;
            carry_d = bus_io.cin;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            sum_d[idx_q*N +: N] = chunkSum;
            carry_d             = chunkCarry;
            idx_d               = idx_q + IW'(1);
            if (lastChunk) begin
                idx_d  = '0;
                cout_d = chunkCarry;
`ifdef CHUNK_ADD_SEQ_OVF_EN
                ovf_d  = msbCarryIn ^ chunkCarry;
`endif
            end
        end
    end

    assign bus_io.sum  = sum_q;
    assign bus_io.cout = cout_q;
`ifdef CHUNK_ADD_SEQ_OVF_EN
    assign bus_io.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_chunk_add_seq.sv
// Scoreboard bench for chunk_add_seq: a K=4 and a K=1 instance, directed vectors.
// Build with CHUNK_ADD_SEQ_OVF_EN defined to also check ovf.
module tb_chunk_add_seq;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertions = 0;
    int   failures   = 0;
    exp_t q4[$];
    exp_t q1[$];
    exp_t mon4E, mon1E;

    always #5 clk = ~clk;

    chunk_add_seq_if #(.N(8), .K(4)) bus4 ();
    chunk_add_seq_if #(.N(8), .K(1)) bus1 ();

    chunk_add_seq #(.N(8), .K(4)) dut4 (.clk(clk), .rst(rst), .bus_io(bus4));
    chunk_add_seq #(.N(8), .K(1)) dut1 (.clk(clk), .rst(rst), .bus_io(bus1));

    function automatic exp_t mkExp(input logic [31:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitors pop the scoreboard whenever a done pulse appears.
    always @(negedge clk) begin
        if (bus4.done === 1'b1) begin
            checkOutput("busyDone4", {63'd0, bus4.busy}, 64'd0);
            if (q4.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpectedDone4: got done=1, expected no pending result at %0t", $time);
            end else begin
                mon4E = q4.pop_front();
                checkOutput("sum4", {32'd0, bus4.sum}, {32'd0, mon4E.sum});
                checkOutput("cout4", {63'd0, bus4.cout}, {63'd0, mon4E.cout});
`ifdef CHUNK_ADD_SEQ_OVF_EN
                checkOutput("ovf4", {63'd0, bus4.ovf}, {63'd0, mon4E.ovf});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.done === 1'b1) begin
            checkOutput("busyDone1", {63'd0, bus1.busy}, 64'd0);
            if (q1.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpectedDone1: got done=1, expected no pending result at %0t", $time);
            end else begin
                mon1E = q1.pop_front();
                checkOutput("sum1", {56'd0, bus1.sum}, {56'd0, mon1E.sum[7:0]});
                checkOutput("cout1", {63'd0, bus1.cout}, {63'd0, mon1E.cout});
`ifdef CHUNK_ADD_SEQ_OVF_EN
                checkOutput("ovf1", {63'd0, bus1.ovf}, {63'd0, mon1E.ovf});
`endif
            end
        end
    end

    task automatic applyStimulus(input int unit, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input exp_t e, input bit push);
        @(negedge clk);
        if (unit == 4) begin
            bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.start = 1'b1;
            if (push) q4.push_back(e);
        end else begin
            bus1.a = a[7:0]; bus1.b = b[7:0]; bus1.cin = cin; bus1.start = 1'b1;
            if (push) q1.push_back(e);
        end
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    // Issue one request and check busy/done timing plus sum hold after done.
    task automatic runVector(input int unit, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input exp_t e);
        int   kk;
        logic bsy, dn;
        logic [31:0] s;
        kk = (unit == 4) ? 4 : 1;
        applyStimulus(unit, a, b, cin, e, 1'b1);
        for (int i = 1; i <= kk + 1; i++) begin
            @(negedge clk);
            bsy = (unit == 4) ? bus4.busy : bus1.busy;
            dn  = (unit == 4) ? bus4.done : bus1.done;
            checkOutput("busyTiming", {63'd0, bsy}, {63'd0, (i <= kk)});
            checkOutput("doneTiming", {63'd0, dn}, {63'd0, (i == kk + 1)});
        end
        @(negedge clk);
        s = (unit == 4) ? bus4.sum : {24'd0, bus1.sum};
        checkOutput("sumHeld", {32'd0, s}, {32'd0, (unit == 4) ? e.sum : {24'd0, e.sum[7:0]}});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstBusy", {63'd0, bus4.busy}, 64'd0);
        checkOutput("rstDone", {63'd0, bus4.done}, 64'd0);
        checkOutput("rstSum", {32'd0, bus4.sum}, 64'd0);
        checkOutput("rstCout", {63'd0, bus4.cout}, 64'd0);
        checkOutput("rstSum1", {56'd0, bus1.sum}, 64'd0);
`ifdef CHUNK_ADD_SEQ_OVF_EN
        checkOutput("rstOvf", {63'd0, bus4.ovf}, 64'd0);
`endif

        runVector(4, 32'h000000FF, 32'h00000001, 1'b0, mkExp(32'h00000100, 1'b0, 1'b0));
        runVector(4, 32'hFFFFFFFF, 32'h00000000, 1'b1, mkExp(32'h00000000, 1'b1, 1'b0));
        runVector(4, 32'h12345678, 32'h9ABCDEF0, 1'b0, mkExp(32'hACF13568, 1'b0, 1'b0));
        runVector(4, 32'h80000000, 32'h80000000, 1'b0, mkExp(32'h00000000, 1'b1, 1'b1));
        runVector(4, 32'h7FFFFFFF, 32'h00000001, 1'b0, mkExp(32'h80000000, 1'b0, 1'b1));
        runVector(4, 32'hFFFFFFFF, 32'h00000001, 1'b0, mkExp(32'h00000000, 1'b1, 1'b0));

        // start held high; operands changed mid-run must not leak into the running sum
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 32'h00000001; bus4.b = 32'h00000002; bus4.cin = 1'b0;
        q4.push_back(mkExp(32'h00000003, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        bus4.a = 32'h10000000; bus4.b = 32'h01000000;
        q4.push_back(mkExp(32'h11000000, 1'b0, 1'b0));
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checkOutput("b2bDone", {63'd0, bus4.done}, {63'd0, (i % 5 == 0)});
            checkOutput("b2bBusy", {63'd0, bus4.busy}, {63'd0, (i % 5 != 0)});
            if (i == 6) begin
                bus4.a = 32'hFFFFFFFF; bus4.b = 32'h00000002;
                q4.push_back(mkExp(32'h00000001, 1'b1, 1'b0));
            end
            if (i == 11) bus4.start = 1'b0;
        end

        // reset sampled at E0+2 aborts the sum with no done
        applyStimulus(4, 32'h0000FFFF, 32'h00000001, 1'b0, mkExp(32'h0, 1'b0, 1'b0), 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", {63'd0, bus4.busy}, 64'd0);
        checkOutput("abortDone", {63'd0, bus4.done}, 64'd0);
        checkOutput("abortSum", {32'd0, bus4.sum}, 64'd0);
        checkOutput("abortCout", {63'd0, bus4.cout}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("noDoneAfterAbort", {63'd0, bus4.done}, 64'd0);
        end
        runVector(4, 32'h0000FFFF, 32'h00000001, 1'b0, mkExp(32'h00010000, 1'b0, 1'b0));

        runVector(1, 32'h000000F0, 32'h00000020, 1'b0, mkExp(32'h00000010, 1'b1, 1'b0));
        runVector(1, 32'h0000007F, 32'h00000001, 1'b0, mkExp(32'h00000080, 1'b0, 1'b1));
        runVector(1, 32'h000000FF, 32'h00000000, 1'b1, mkExp(32'h00000000, 1'b1, 1'b0));

        repeat (4) @(negedge clk);
        checkOutput("q4Drained", 64'(q4.size()), 64'd0);
        checkOutput("q1Drained", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/chunk_add_seq.md
# chunk_add_seq

Multi-precision adder sequencer: adds two N*K-bit operands by driving a single N-bit ripple-carry adder datapath over K consecutive cycles, least-significant chunk first. The block registers the inter-chunk carry and assembles the result. It sits between a requesting client and one shared N-bit adder instance, trading latency for area when wide additions are infrequent.

## Interface
- N, 8: chunk width in bits; width of the internal adder datapath; ≥1
- K, 4: number of chunks; operand width W = N*K; ≥1
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when the block is not busy
- a  input  W  operand A; captured on accepted start
- b  input  W  operand B; captured on accepted start
- cin  input  1  carry into chunk 0; captured on accepted start
- busy  output  1  high while a sum is in progress
- done  output  1  single-cycle pulse: result is valid
- sum  output  W  result; held stable until the next accepted start
- cout  output  1  carry out of the most-significant chunk; held with sum

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: capture a, b and cin into internal registers; chunk index idx=0; carry register = cin; go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - Feed chunk idx of both operands plus the carry register to the N-bit adder.
  - Write the N-bit result into sum[idx*N +: N].
  - Load the adder carry-out into the carry register.
  - Increment idx.
- RUN transition: when idx=K-1, after the write go to DONE and load cout from the final carry.
- DONE: done=1 for exactly one cycle. With start=1, accept a new request as from IDLE (back-to-back) and go to RUN. Otherwise go to IDLE.
- The start input is ignored in RUN. Operand inputs are don't-care except at accept.
- The captured operands are private copies. Input changes during RUN do not affect the result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1). No saturation.
- sum and cout keep the previous result until overwritten. In RUN, sum is partially updated and is only valid when done=1 or afterwards.
- K=1: RUN lasts one cycle; the block behaves as a registered N-bit adder with a handshake.

## Timing
- Reset: state=IDLE, idx=0, carry=0, busy=0, done=0, sum=0, cout=0.
- A reset asserted mid-operation aborts the sum immediately. The partial result is discarded, all outputs take their reset values, and no done is produced.
- start is accepted at edge E0. busy=1 in the K cycles after edges E0..E0+K-1. done=1 in the cycle after edge E0+K. Latency from start to done is K+1 edges.
- Back-to-back: a start accepted at the edge that leaves DONE gives a throughput of one sum per K+1 cycles.
- busy and done are never high simultaneously. done never stays high for two consecutive cycles.
- The adder datapath is combinational within one cycle. The critical path is one N-bit ripple chain plus the carry register.

## Configuration
- CHUNK_ADD_SEQ_OVF_EN:
  - When defined, adds output port ovf (1 bit). ovf is the signed (two's-complement) overflow of the W-bit add: the carry into bit W-1 XOR the carry out of bit W-1. It is computed on the final chunk and updated and held together with cout. Its reset value is 0.
  - When undefined, the port and its logic are absent and behaviour is otherwise identical.

## Test plan
- N=8, K=4, a=0x000000FF, b=0x00000001, cin=0, start at E0 → busy for 4 cycles; done after E0+4; sum=0x00000100, cout=0.
- a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1, exercising the carry through all chunks.
- start held high continuously with operands changed mid-RUN → the first result uses only the captured operands; a second accept occurs at the DONE edge; done pulses every 5 cycles.
- rst asserted for one cycle at E0+2 → next cycle: busy=0, done=0, sum=0, cout=0; no done pulse follows; a new start then completes normally.
- K=1, N=8, a=0xF0, b=0x20, cin=0 → done one edge after accept; sum=0x10, cout=1.
- With CHUNK_ADD_SEQ_OVF_EN: a=0x7FFFFFFF, b=0x00000001 gives ovf=1, cout=0. Then a=0xFFFFFFFF, b=0x00000001 gives ovf=0, cout=1.
